// File: rtl/turn_controller.sv
// Chess-clock game sequencer: turn/pause FSM, Fischer increment bursts,
// BCD full-move counter and timeout result latch.
module turn_controller #(
    parameter int unsigned INC_SECONDS = 3
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CE,
    input  logic        START,
    input  logic        SELECT,
    input  logic        STOP,
    input  logic        OVERFLOW1,
    input  logic        OVERFLOW2,
    output logic        Enable_p1,
    output logic        Enable_p2,
    output logic        INC_p1,
    output logic        INC_p2,
    output logic [11:0] MOVES,
    output logic        END,
    output logic [1:0]  WINNER,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRunP1 = 3'd1,
        StRunP2 = 3'd2,
        StInc   = 3'd3,
        StPause = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [3:0] INC_CNT = 4'(INC_SECONDS);
    localparam bit         INC_EN  = (INC_SECONDS != 0);

    state_e      state;
    logic        start_prev;
    logic        select_prev;
    logic [3:0]  burst_cnt;
    logic        saved_p2;
    logic        inc1_q;
    logic        inc2_q;
    logic        start_edge;
    logic        select_edge;
    logic        run_p2;
    logic        own_ovf;
    logic [11:0] moves_next;

    assign start_edge  = START & ~start_prev;
    assign select_edge = SELECT & ~select_prev;
    assign run_p2      = (state == StRunP2);
    assign own_ovf     = run_p2 ? OVERFLOW2 : OVERFLOW1;

    // Gating by CE keeps a pulse frozen across CE=0 cycles from being seen twice.
    assign INC_p1 = inc1_q & CE;
    assign INC_p2 = inc2_q & CE;
    assign STATE  = state;

    always_comb begin
        moves_next = MOVES;
        if (MOVES[3:0] != 4'd9) begin
            moves_next[3:0] = MOVES[3:0] + 4'd1;
        end else begin
            moves_next[3:0] = 4'd0;
            if (MOVES[7:4] != 4'd9) begin
                moves_next[7:4] = MOVES[7:4] + 4'd1;
            end else begin
                moves_next[7:4] = 4'd0;
                moves_next[11:8] = (MOVES[11:8] == 4'd9) ? 4'd0 : MOVES[11:8] + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state       <= StIdle;
            start_prev  <= 1'b0;
            select_prev <= 1'b0;
            burst_cnt   <= 4'd0;
            saved_p2    <= 1'b0;
            inc1_q      <= 1'b0;
            inc2_q      <= 1'b0;
            Enable_p1   <= 1'b0;
            Enable_p2   <= 1'b0;
            MOVES       <= 12'h000;
            END         <= 1'b0;
            WINNER      <= 2'b00;
        end else if (CE) begin
            start_prev  <= START;
            select_prev <= SELECT;
            inc1_q      <= 1'b0;
            inc2_q      <= 1'b0;
            case (state)
                StIdle: begin
                    Enable_p1 <= 1'b0;
                    Enable_p2 <= 1'b0;
                    if (start_edge) begin
                        state     <= StRunP1;
                        Enable_p1 <= 1'b1;
                    end
                end
                StRunP1, StRunP2: begin
                    if (own_ovf) begin
                        state     <= StDone;
                        Enable_p1 <= 1'b0;
                        Enable_p2 <= 1'b0;
                        END       <= 1'b1;
                        WINNER    <= run_p2 ? 2'b01 : 2'b10;
                    end else if (STOP) begin
                        state     <= StPause;
                        Enable_p1 <= 1'b0;
                        Enable_p2 <= 1'b0;
                        saved_p2  <= run_p2;
                    end else if (select_edge) begin
                        if (run_p2) begin
                            MOVES <= moves_next;
                        end
                        if (INC_EN) begin
                            state     <= StInc;
                            burst_cnt <= INC_CNT;
                            saved_p2  <= run_p2;
                            Enable_p1 <= 1'b0;
                            Enable_p2 <= 1'b0;
                        end else begin
                            state     <= run_p2 ? StRunP1 : StRunP2;
                            Enable_p1 <= run_p2;
                            Enable_p2 <= ~run_p2;
                        end
                    end
                end
                StInc: begin
                    if (burst_cnt != 4'd0) begin
                        burst_cnt <= burst_cnt - 4'd1;
                        inc1_q    <= ~saved_p2;
                        inc2_q    <= saved_p2;
                    end else begin
                        state     <= saved_p2 ? StRunP1 : StRunP2;
                        Enable_p1 <= saved_p2;
                        Enable_p2 <= ~saved_p2;
                    end
                end
                StPause: begin
                    if (!STOP) begin
                        state     <= saved_p2 ? StRunP2 : StRunP1;
                        Enable_p1 <= ~saved_p2;
                        Enable_p2 <= saved_p2;
                    end
                end
                StDone: begin
                    if (start_edge) begin
                        state  <= StIdle;
                        END    <= 1'b0;
                        WINNER <= 2'b00;
                        MOVES  <= 12'h000;
                    end
                end
                default: begin
                    state     <= StIdle;
                    Enable_p1 <= 1'b0;
                    Enable_p2 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: one instance with a 3 s increment,
// one with the increment disabled for the move-counter wrap.
`timescale 1ns/1ps
module tb_turn_controller;

    logic        clk = 1'b0;
    logic        clr, ce, start, sel, stop, ovf1, ovf2;
    logic        en1, en2, inc1, inc2, game_end;
    logic [11:0] moves;
    logic [1:0]  winner;
    logic [2:0]  state;
    logic        z_en1, z_en2, z_inc1, z_inc2, z_end;
    logic [11:0] z_moves;
    logic [1:0]  z_winner;
    logic [2:0]  z_state;

    int n_vec = 0;
    int n_err = 0;
    int pc1 = 0;
    int pc2 = 0;

    turn_controller #(.INC_SECONDS(3)) dut (
        .CLK(clk), .CLR(clr), .CE(ce), .START(start), .SELECT(sel), .STOP(stop),
        .OVERFLOW1(ovf1), .OVERFLOW2(ovf2), .Enable_p1(en1), .Enable_p2(en2),
        .INC_p1(inc1), .INC_p2(inc2), .MOVES(moves), .END(game_end),
        .WINNER(winner), .STATE(state)
    );

    turn_controller #(.INC_SECONDS(0)) dut0 (
        .CLK(clk), .CLR(clr), .CE(ce), .START(start), .SELECT(sel), .STOP(stop),
        .OVERFLOW1(ovf1), .OVERFLOW2(ovf2), .Enable_p1(z_en1), .Enable_p2(z_en2),
        .INC_p1(z_inc1), .INC_p2(z_inc2), .MOVES(z_moves), .END(z_end),
        .WINNER(z_winner), .STATE(z_state)
    );

    always #5 clk = ~clk;

    // Pulses are counted once per cycle, mid-cycle, where CE is stable.
    always @(negedge clk) begin
        if (inc1) pc1 <= pc1 + 1;
        if (inc2) pc2 <= pc2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input bit to_p2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("burst_pulse", to_p2 ? inc2 : inc1, 1);
            check("burst_other", to_p2 ? inc1 : inc2, 0);
            check("burst_en", {en1, en2}, 2'b00);
        end
        tick();
        check("post_burst_state", state, to_p2 ? 3'd1 : 3'd2);
        check("post_burst_en", {en1, en2}, to_p2 ? 2'b10 : 2'b01);
        check("post_burst_pulse", {inc1, inc2}, 2'b00);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] exp_mv;
        clr   = 1'b0;
        ce    = 1'($urandom);
        start = 1'($urandom);
        sel   = 1'($urandom);
        stop  = 1'($urandom);
        ovf1  = 1'($urandom);
        ovf2  = 1'($urandom);
        repeat (2) tick();
        check("rst_state", state, 0);
        check("rst_outs", {en1, en2, inc1, inc2, game_end, winner}, 0);
        check("rst_moves", moves, 0);

        {ce, start, sel, stop, ovf1, ovf2} = 6'b100000;
        clr = 1'b1;
        tick();
        check("idle_state", state, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_state", state, 1);
        check("start_en", {en1, en2}, 2'b10);
        tick();

        // P1 moves: burst of three pulses to P1, then P2 runs
        sel = 1'b1; tick(); sel = 1'b0;
        check("inc_entry_state", state, 3);
        check("inc_entry_en", {en1, en2, inc1, inc2}, 0);
        expect_burst(1'b0);
        check("moves_after_p1", moves, 12'h000);
        sel = 1'b1; tick(); sel = 1'b0;
        check("moves_after_p2", moves, 12'h001);
        expect_burst(1'b1);
        sel = 1'b1; tick(); sel = 1'b0;
        expect_burst(1'b0);

        // Pause in RUN_P2 with SELECT toggling
        stop = 1'b1; tick();
        check("pause_state", state, 4);
        check("pause_en", {en1, en2}, 2'b00);
        sel = 1'b1; tick(); sel = 1'b0; tick(); sel = 1'b1; tick();
        check("pause_sel_state", state, 4);
        check("pause_sel_moves", moves, 12'h001);
        stop = 1'b0; tick();
        check("resume_state", state, 2);
        check("resume_en", {en1, en2}, 2'b01);
        tick();
        check("held_sel_state", state, 2);
        sel = 1'b0; tick();

        // STOP beats a simultaneous SELECT edge
        stop = 1'b1; sel = 1'b1; tick();
        check("stop_sel_state", state, 4);
        check("stop_sel_moves", moves, 12'h001);
        stop = 1'b0; tick();
        check("stop_sel_resume", state, 2);
        sel = 1'b0; tick();
        sel = 1'b1; tick(); sel = 1'b0;
        check("moves_two", moves, 12'h002);
        expect_burst(1'b1);

        // Timeouts in RUN_P1
        ovf2 = 1'b1; tick(); tick();
        check("ovf2_ignored_state", state, 1);
        check("ovf2_ignored_en", {en1, en2}, 2'b10);
        ovf2 = 1'b0;
        pc1 = 0; pc2 = 0;
        ovf1 = 1'b1; sel = 1'b1; tick(); sel = 1'b0;
        check("timeout_state", state, 5);
        check("timeout_end", game_end, 1);
        check("timeout_winner", winner, 2'b10);
        check("timeout_en", {en1, en2}, 2'b00);
        tick(); tick();
        ovf1 = 1'b0;
        check("timeout_hold", state, 5);
        check("timeout_pulses", pc1 + pc2, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("done_to_idle", state, 0);
        check("idle_cleared", {game_end, winner}, 0);
        check("idle_moves", moves, 12'h000);
        tick();

        // Reset after the first burst pulse
        start = 1'b1; tick(); start = 1'b0;
        sel = 1'b1; tick(); sel = 1'b0;
        tick();
        check("midburst_pulse", inc1, 1);
        clr = 1'b0; #1;
        check("async_rst_state", state, 0);
        check("async_rst_pulse", {inc1, inc2, en1, en2}, 0);
        pc1 = 0; pc2 = 0;
        tick(); clr = 1'b1;
        repeat (5) tick();
        check("post_rst_pulses", pc1 + pc2, 0);
        check("post_rst_state", state, 0);

        // CE held low mid-burst
        start = 1'b1; tick(); start = 1'b0;
        sel = 1'b1; tick(); sel = 1'b0;
        pc1 = 0; pc2 = 0;
        tick();
        ce = 1'b0;
        repeat (5) tick();
        check("ce_frozen_state", state, 3);
        check("ce_frozen_pulses", pc1, 0);
        ce = 1'b1;
        for (int i = 0; i < 10 && state != 3'd2; i++) tick();
        check("ce_exit_state", state, 2);
        check("ce_pulse_total", pc1, 3);
        check("ce_pulse_other", pc2, 0);

        // Move counter wrap on the no-increment instance
        clr = 1'b0; #1; clr = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("z_start_state", z_state, 1);
        for (int m = 1; m <= 1000; m++) begin
            sel = 1'b1; tick();
            if (m == 1) check("z_direct_p2", z_state, 2);
            sel = 1'b0; tick();
            sel = 1'b1; tick();
            sel = 1'b0; tick();
            if (m == 1 || m == 99 || m == 100 || m == 999 || m == 1000) begin
                case (m)
                    1:       exp_mv = 12'h001;
                    99:      exp_mv = 12'h099;
                    100:     exp_mv = 12'h100;
                    999:     exp_mv = 12'h999;
                    default: exp_mv = 12'h000;
                endcase
                check("z_moves", z_moves, exp_mv);
            end
        end
        check("z_no_pulses", {z_inc1, z_inc2}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game sequencer for the chess clock.
- Owns the turn and pause state, and decides which player timer may count down.
- Schedules the Fischer increment as a burst of one-second add pulses into the timer of the player who just moved.
- Keeps a BCD full-move counter and latches the game result when a timer overflows.
- Sits between the button inputs, the two player timers (enable/overflow) and the display path.

Parameters:
- INC_SECONDS, 3, seconds added to the mover's timer after each move (0..15; 0 disables the burst).

Ports:
- CLK  in  1  system clock
- CLR  in  1  asynchronous active-low reset
- CE  in  1  global clock enable; state advances only in cycles with CE=1
- START  in  1  level; rising edge starts a game (IDLE) or returns to IDLE (DONE)
- SELECT  in  1  turn button level; rising edge = running player finished a move
- STOP  in  1  level; high pauses the game
- OVERFLOW1  in  1  player-1 timer reached 00:00 (level)
- OVERFLOW2  in  1  player-2 timer reached 00:00 (level)
- Enable_p1  out  1  player-1 timer count enable
- Enable_p2  out  1  player-2 timer count enable
- INC_p1  out  1  one-cycle pulse: add one second to player 1
- INC_p2  out  1  one-cycle pulse: add one second to player 2
- MOVES  out  12  BCD full-move count, digits [11:8][7:4][3:0]
- END  out  1  game over
- WINNER  out  2  01 = player 1 won, 10 = player 2 won, 00 = none
- STATE  out  3  encoded FSM state (debug)

Behaviour:
- **Reset:** CLR=0 asynchronously forces state IDLE and clears all outputs to 0, MOVES=000, WINNER=00, the edge registers, the burst counter and the saved player. Reset mid-burst or mid-game abandons everything with no residual pulses.
- **Edge detection:** START and SELECT previous-value registers update only when CE=1. An edge is seen in the CE cycle where current=1 and previous=0. A held button never retriggers.
- **Register timing:** All outputs are registered (Moore). A decision made in CE cycle n appears at the outputs on the clock edge ending cycle n.
- **States:** IDLE=0, RUN_P1=1, RUN_P2=2, INC=3, PAUSE=4, DONE=5.
- **IDLE:** Both enables 0. START edge -> RUN_P1 (player 1 moves first).
- **RUN_Px:** Enable_px=1, the other enable 0. Priority, highest first:
  - Overflow of the running player -> DONE, with WINNER set to the opponent and END=1. An overflow of the non-running player is ignored.
  - STOP=1 -> PAUSE; the saved player is x.
  - SELECT edge:
    - If INC_SECONDS>0: -> INC with target=x and burst counter=INC_SECONDS.
    - If INC_SECONDS=0: -> directly to the other player's RUN state.
    - If x=2, MOVES increments on the same edge.
- **INC:**
  - Both enables 0.
  - One INC_px pulse (for the target player) is emitted per CE cycle; the counter decrements each time.
  - After exactly INC_SECONDS pulses -> RUN of the other player.
  - STOP, SELECT and overflow are not acted on during INC.
  - A STOP still high on exit takes effect in the following CE cycle.
  - INC_p1 and INC_p2 are never high simultaneously.
- **PAUSE:**
  - Both enables 0; SELECT edges are ignored, but the edge register keeps tracking.
  - STOP=0 -> RUN of the saved player.
  - START edge is ignored.
- **DONE:**
  - END=1 and WINNER is held; both enables 0; INC pulses 0.
  - START edge -> IDLE, which clears END, WINNER and MOVES.
- **MOVES:** Three-digit BCD. A digit rolls 9->0 with carry; 999 wraps to 000.
- **CE=0:** State, counter, outputs and edge registers are all frozen. INC pulses are not emitted in CE=0 cycles, so each pulse is exactly one CE-qualified cycle wide (CE=0 cycles in between do not create extra pulses).
- **Simultaneous events:**
  - Running-player overflow together with a SELECT edge: overflow wins and no increment is issued.
  - STOP together with a SELECT edge in RUN: STOP wins and the SELECT edge is discarded.

Test Plan:
- **Reset:** CLR low with random inputs -> all outputs 0, STATE=0. Release CLR, hold CE=1, pulse START -> next cycle STATE=1, Enable_p1=1, Enable_p2=0.
- **Increment and move count:** INC_SECONDS=3, in RUN_P1 raise SELECT -> exactly 3 consecutive INC_p1 pulses with both enables 0, then Enable_p2=1. A second SELECT edge gives 3 INC_p2 pulses, then Enable_p1=1 and MOVES=001.
- **Pause:** In RUN_P2 raise STOP -> STATE=4 and both enables 0. Toggle SELECT during the pause -> no change. Drop STOP -> Enable_p2=1.
- **Timeout:**
  - In RUN_P1 assert OVERFLOW1 with a simultaneous SELECT edge -> DONE, END=1, WINNER=10, no INC pulses.
  - OVERFLOW2 asserted in RUN_P1 -> ignored.
- **MOVES wrap:** Play 1000 full moves with INC_SECONDS=0 -> MOVES passes 099->100 and 999->000.
- **Reset mid-burst and CE gating:** CLR asserted after the first INC pulse -> no further pulses, STATE=0. Separately, holding CE=0 for 5 cycles mid-burst -> pulse count is unchanged at 3 total.
